// File: rtl/esfa_pkg.sv
// Shared types for the ESFA symbol-stream blocks: default widths, FSM state
// encoding and the latched verdict code.
package esfa_pkg;

    localparam int SYM_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_V = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        VD_NONE    = 2'd0,
        VD_ACCEPT  = 2'd1,
        VD_REJECT  = 2'd2,
        VD_TIMEOUT = 2'd3
    } verdict_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_SEND) || (s == ST_WAIT_V);
    endfunction

endpackage

// File: rtl/esfa_sym_buf.sv
// String buffer: DEPTH x SYM_W register array, one write port addressed by the
// append index and an asynchronous read port addressed by the stream pointer.
module esfa_sym_buf #(
    parameter int SYM_W = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_idx,
    input  logic [SYM_W-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_idx,
    output logic [SYM_W-1:0] rd_data
);

    logic [SYM_W-1:0] mem [DEPTH];

    // NOTE: the array is deliberately not reset; the owner's count says which
    // entries hold valid data, so clearing storage would only cost reset fanout.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/esfa_symbol_tx.sv
// Transmit side of the ESFA symbol stream: buffers a host-loaded string, streams
// it over valid/ready with a last marker, then latches the engine's verdict.
module esfa_symbol_tx
    import esfa_pkg::*;
#(
    parameter int SYM_W       = SYM_W_DEF,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [SYM_W-1:0]         wr_data,
    input  logic                     clear,
    input  logic                     start,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     sym_valid,
    output logic [SYM_W-1:0]         sym_data,
    output logic                     sym_last,
    input  logic                     sym_ready,
    input  logic                     verdict_valid,
    input  logic                     verdict_accept,
    output logic                     done,
    output logic                     accept,
    output logic                     timeout,
    output logic                     err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_EXPIRE = TMR_W'(TIMEOUT_CYC - 1);

    state_t           state, state_n;
    verdict_t         verdict, verdict_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             err_q, err_n;
    logic             buf_we;
    logic [SYM_W-1:0] rd_data;
    logic             full;
    logic             at_last;
    logic             req_any;

    esfa_sym_buf #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (count_q[PTR_W-1:0]),
        .wr_data (wr_data),
        .rd_idx  (rd_ptr),
        .rd_data (rd_data)
    );

    assign full    = (count_q == CNT_FULL);
    assign at_last = ({1'b0, rd_ptr} == (count_q - CNT_W'(1)));
    assign req_any = wr_en | start | clear;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            verdict <= VD_NONE;
            count_q <= '0;
            rd_ptr  <= '0;
            timer   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            verdict <= verdict_n;
            count_q <= count_n;
            rd_ptr  <= rd_ptr_n;
            timer   <= timer_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        // NOTE: every next-value is defaulted first so no path can infer a latch.
        state_n   = state;
        verdict_n = verdict;
        count_n   = count_q;
        rd_ptr_n  = rd_ptr;
        timer_n   = timer;
        err_n     = 1'b0;
        buf_we    = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (clear) begin
                    count_n   = '0;
                    verdict_n = VD_NONE;
                    state_n   = ST_IDLE;
                end else begin
                    if (wr_en) begin
                        if (full) begin
                            err_n = 1'b1;
                        end else begin
                            buf_we  = 1'b1;
                            count_n = count_q + CNT_W'(1);
                        end
                    end
                    // A write in the same cycle counts toward the start check.
                    if (start) begin
                        if (count_n == '0) begin
                            err_n = 1'b1;
                        end else begin
                            state_n   = ST_SEND;
                            rd_ptr_n  = '0;
                            verdict_n = VD_NONE;
                        end
                    end
                end
            end

            ST_SEND: begin
                err_n = req_any;
                if (sym_ready) begin
                    rd_ptr_n = rd_ptr + PTR_W'(1);
                    if (at_last) begin
                        state_n = ST_WAIT_V;
                        timer_n = '0;
                    end
                end
            end

            ST_WAIT_V: begin
                err_n = req_any;
                if (verdict_valid) begin
                    state_n   = ST_DONE;
                    verdict_n = verdict_accept ? VD_ACCEPT : VD_REJECT;
                end else if (timer == TMR_EXPIRE) begin
                    state_n   = ST_DONE;
                    verdict_n = VD_TIMEOUT;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Stream outputs decode directly from registers, so they cannot glitch or
    // change while the engine stalls; sym_data is zeroed outside SEND.
    assign sym_valid = (state == ST_SEND);
    assign sym_data  = sym_valid ? rd_data : '0;
    assign sym_last  = sym_valid & at_last;

    assign count   = count_q;
    assign busy    = is_busy(state);
    assign err     = err_q;
    assign done    = (verdict != VD_NONE);
    assign accept  = (verdict == VD_ACCEPT);
    assign timeout = (verdict == VD_TIMEOUT);

endmodule

// File: tb/tb_esfa_symbol_tx.sv
// Self-checking bench for esfa_symbol_tx: table-driven buffer loading plus
// hand-written transfer sequences checked against a symbol scoreboard.
module tb_esfa_symbol_tx;

    localparam int SYM_W       = 8;
    localparam int DEPTH       = 16;
    localparam int TIMEOUT_CYC = 255;
    localparam int CNT_W       = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [SYM_W-1:0] wr_data;
    logic             clear;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             sym_valid;
    logic [SYM_W-1:0] sym_data;
    logic             sym_last;
    logic             sym_ready;
    logic             verdict_valid;
    logic             verdict_accept;
    logic             done;
    logic             accept;
    logic             timeout;
    logic             err;

    esfa_symbol_tx #(
        .SYM_W       (SYM_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .clear          (clear),
        .start          (start),
        .count          (count),
        .busy           (busy),
        .sym_valid      (sym_valid),
        .sym_data       (sym_data),
        .sym_last       (sym_last),
        .sym_ready      (sym_ready),
        .verdict_valid  (verdict_valid),
        .verdict_accept (verdict_accept),
        .done           (done),
        .accept         (accept),
        .timeout        (timeout),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SYM_W-1:0] data;
        logic             last;
    } sym_t;

    typedef struct {
        logic             clr;
        logic             wr;
        logic [SYM_W-1:0] d;
        logic             st;
        int               exp_count;
        logic             exp_err;
        logic             exp_busy;
    } vec_t;

    int               checks = 0;
    int               errors = 0;
    int               hs_cnt = 0;
    sym_t             exp_q[$];
    logic [SYM_W-1:0] model[$];
    vec_t             vecs[$];

    logic             hold_pending = 1'b0;
    logic [SYM_W-1:0] hold_data;
    logic             hold_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en          = 1'b0;
        start          = 1'b0;
        clear          = 1'b0;
        verdict_valid  = 1'b0;
        verdict_accept = 1'b0;
    endtask

    task automatic expect_model();
        for (int i = 0; i < model.size(); i++) begin
            sym_t s;
            s.data = model[i];
            s.last = (i == model.size() - 1);
            exp_q.push_back(s);
        end
    endtask

    // Tick until the stream has finished, bounded by a cycle budget.
    task automatic wait_send_done(input string tag, input int budget);
        int n = 0;
        while (sym_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_busy_novalid"}, {busy, sym_valid}, 32'b10);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    task automatic start_and_reach_wait_v(input string tag);
        expect_model();
        sym_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_send_done(tag, 3 * DEPTH);
        sym_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic c, input logic w, input logic [SYM_W-1:0] d,
                                input logic s, input int n, input logic e, input logic b);
        vec_t v;
        v.clr = c; v.wr = w; v.d = d; v.st = s;
        v.exp_count = n; v.exp_err = e; v.exp_busy = b;
        return v;
    endfunction

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", sym_valid, 1);
                check("hold_data", sym_data, hold_data);
                check("hold_last", sym_last, hold_last);
                hold_pending = 1'b0;
            end
            if (sym_valid && sym_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_symbol", exp_q.size(), 1);
                end else begin
                    sym_t s;
                    s = exp_q.pop_front();
                    check("sb_data", sym_data, s.data);
                    check("sb_last", sym_last, s.last);
                end
            end else if (sym_valid) begin
                hold_pending = 1'b1;
                hold_data    = sym_data;
                hold_last    = sym_last;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        wr_data   = '0;
        sym_ready = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_sym_data", sym_data, 0);
        check("rst_sym_last", sym_last, 0);
        check("rst_done", done, 0);
        check("rst_accept", accept, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Buffer loading, overflow and empty-start table
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < DEPTH; i++) vecs.push_back(mk(0, 1, 8'hA0 + 8'(i), 0, i + 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFF, 0, DEPTH, 1, 0));
        vecs.push_back(mk(1, 1, 8'h55, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h61, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h62, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h63, 0, 3, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            clear   = vecs[i].clr;
            wr_en   = vecs[i].wr;
            wr_data = vecs[i].d;
            start   = vecs[i].st;
            tick();
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
        end
        idle_inputs();
        model = '{8'h61, 8'h62, 8'h63};

        // Zero-bubble stream, then verdict two cycles after the last symbol
        hs_cnt = 0;
        expect_model();
        sym_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_sym0", sym_data, 8'h61);
        check("t1_last0", sym_last, 0);
        tick();
        check("t1_sym1", sym_data, 8'h62);
        tick();
        check("t1_sym2", sym_data, 8'h63);
        check("t1_last2", sym_last, 1);
        tick();
        check("t1_after_last", {busy, sym_valid}, 32'b10);
        check("t1_handshakes", hs_cnt, 3);
        check("t1_sb_drained", exp_q.size(), 0);
        sym_ready = 1'b0;
        tick();
        verdict_valid  = 1'b1;
        verdict_accept = 1'b1;
        tick();
        idle_inputs();
        check("t1_done", done, 1);
        check("t1_accept", accept, 1);
        check("t1_timeout", timeout, 0);
        check("t1_busy_end", busy, 0);

        // Back-pressure pattern 1,0,0,1
        begin
            logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
            int n = 0;
            hs_cnt = 0;
            expect_model();
            start = 1'b1;
            tick();
            start = 1'b0;
            while (sym_valid && n < 40) begin
                sym_ready = pat[n % 4];
                tick();
                n++;
            end
            sym_ready = 1'b0;
            check("t2_busy_novalid", {busy, sym_valid}, 32'b10);
            check("t2_handshakes", hs_cnt, 3);
            check("t2_sb_drained", exp_q.size(), 0);
            verdict_valid  = 1'b1;
            verdict_accept = 1'b0;
            tick();
            idle_inputs();
            check("t2_done", done, 1);
            check("t2_reject", accept, 0);
        end

        // Verdict timeout: exactly TIMEOUT_CYC cycles after WAIT_V entry
        start_and_reach_wait_v("t4a");
        repeat (TIMEOUT_CYC - 1) tick();
        check("t4a_pre_done", done, 0);
        check("t4a_pre_timeout", timeout, 0);
        check("t4a_pre_busy", busy, 1);
        tick();
        check("t4a_timeout", timeout, 1);
        check("t4a_accept", accept, 0);
        check("t4a_done", done, 1);
        check("t4a_busy", busy, 0);

        // Verdict on the expiry cycle wins over the timeout
        start_and_reach_wait_v("t4b");
        repeat (TIMEOUT_CYC - 1) tick();
        verdict_valid  = 1'b1;
        verdict_accept = 1'b1;
        tick();
        idle_inputs();
        check("t4b_done", done, 1);
        check("t4b_accept", accept, 1);
        check("t4b_timeout", timeout, 0);

        // verdict_valid outside WAIT_V is ignored
        verdict_valid  = 1'b1;
        verdict_accept = 1'b0;
        tick();
        idle_inputs();
        check("t5_ignored_accept", accept, 1);
        check("t5_ignored_err", err, 0);

        // Requests while busy are rejected and leave the buffer alone
        expect_model();
        sym_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("t5_in_send", sym_valid, 1);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("t5_wr_err", err, 1);
        check("t5_wr_count", count, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_start_err", err, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clear_err", err, 1);
        check("t5_clear_count", count, 3);
        check("t5_clear_busy", busy, 1);
        tick();
        check("t5_err_one_cycle", err, 0);
        sym_ready = 1'b1;
        wait_send_done("t5", 3 * DEPTH);
        sym_ready = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("t5_waitv_err", err, 1);
        check("t5_waitv_count", count, 3);
        verdict_valid = 1'b1;
        tick();
        idle_inputs();
        check("t5_done", done, 1);

        // Retransmission after DONE resends the identical string
        hs_cnt = 0;
        start_and_reach_wait_v("t5r");
        check("t5r_handshakes", hs_cnt, 3);
        verdict_valid  = 1'b1;
        verdict_accept = 1'b1;
        tick();
        idle_inputs();
        check("t5r_accept", accept, 1);

        // Asynchronous reset mid-stream
        expect_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_in_send", sym_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", sym_valid, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_count", count, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_post_count", count, 0);
        check("t6_post_busy", busy, 0);
        check("t6_post_done", done, 0);

        // Write and start in the same cycle from an empty buffer
        model = '{8'h41};
        expect_model();
        sym_ready = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'h41;
        start     = 1'b1;
        tick();
        idle_inputs();
        check("t6_ws_busy", busy, 1);
        check("t6_ws_count", count, 1);
        check("t6_ws_err", err, 0);
        check("t6_ws_last", sym_last, 1);
        wait_send_done("t6_ws", 4);
        sym_ready      = 1'b0;
        verdict_valid  = 1'b1;
        verdict_accept = 1'b1;
        tick();
        idle_inputs();
        check("t6_ws_done", done, 1);
        check("t6_ws_accept", accept, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
